// File: rtl/bram16_loader.sv
// bram16_loader: boot-time loader that parses a UART byte stream into bram16 writes.
// Frame layout: SYNC, start address (hi, lo), word count (hi, lo), then big-endian data words.
// The core is held in reset through busy while a frame is in progress.
// Optional macro BRAM16_LOADER_CHECKSUM_EN adds a trailing 8-bit XOR checksum byte.
// The write-data port is named dout because "do" is a reserved word in SystemVerilog.
module bram16_loader #(
    parameter logic [7:0]    SYNC    = 8'hA5,
    parameter int            TW      = 24,
    parameter logic [TW-1:0] TIMEOUT = 24'd1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic        we,
    output logic [15:0] dout,
    output logic [15:0] a,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L
`ifdef BRAM16_LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    // Abort fires on the edge where the idle count would reach TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_reg, state_next;
    logic [15:0]   ptr_reg, ptr_next;      // next write address
    logic [15:0]   cnt_reg, cnt_next;      // remaining words
    logic [7:0]    hi_reg, hi_next;        // latched data high byte
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          fin_reg, fin_next;      // last word written, finish frame next edge
    logic          we_reg, we_next;
    logic [15:0]   dout_reg, dout_next;
    logic [15:0]   a_reg, a_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
`ifdef BRAM16_LOADER_CHECKSUM_EN
    logic [7:0]    csum_reg, csum_next;
`endif

    // Frame parser: next-state, datapath and output decode.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        tmo_next   = tmo_reg;
        fin_next   = 1'b0;
        we_next    = 1'b0;
        dout_next  = dout_reg;
        a_next     = a_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
`ifdef BRAM16_LOADER_CHECKSUM_EN
        csum_next  = csum_reg;
`endif
        // A frame whose last word was just written completes one cycle after we.
        if (fin_reg) begin
            done_next = 1'b1;
            busy_next = 1'b0;
        end
        if (state_reg == IDLE) begin
            tmo_next = '0;
            if (rx_stb && rx_data == SYNC) begin
                state_next = ADDR_H;
                busy_next  = 1'b1;
`ifdef BRAM16_LOADER_CHECKSUM_EN
                csum_next  = 8'h00;
`endif
            end
        end else if (rx_stb) begin
            tmo_next = '0;
`ifdef BRAM16_LOADER_CHECKSUM_EN
            csum_next = csum_reg ^ rx_data;
`endif
            case (state_reg)
                ADDR_H: begin
                    ptr_next[15:8] = rx_data;
                    state_next     = ADDR_L;
                end
                ADDR_L: begin
                    ptr_next[7:0] = rx_data;
                    state_next    = CNT_H;
                end
                CNT_H: begin
                    cnt_next[15:8] = rx_data;
                    state_next     = CNT_L;
                end
                CNT_L: begin
                    cnt_next[7:0] = rx_data;
                    if ({cnt_reg[15:8], rx_data} == 16'h0000) begin
`ifdef BRAM16_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
`endif
                    end else begin
                        state_next = DATA_H;
                    end
                end
                DATA_H: begin
                    hi_next    = rx_data;
                    state_next = DATA_L;
                end
                DATA_L: begin
                    we_next   = 1'b1;
                    dout_next = {hi_reg, rx_data};
                    a_next    = ptr_reg;
                    ptr_next  = ptr_reg + 16'd1;
                    cnt_next  = cnt_reg - 16'd1;
                    if (cnt_reg == 16'd1) begin
`ifdef BRAM16_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
                        fin_next   = 1'b1;
`endif
                    end else begin
                        state_next = DATA_H;
                    end
                end
`ifdef BRAM16_LOADER_CHECKSUM_EN
                CSUM: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    if (rx_data == csum_reg) done_next = 1'b1;
                    else                     err_next  = 1'b1;
                end
`endif
                default: state_next = IDLE;
            endcase
        end else if (tmo_reg == TMO_LAST) begin
            state_next = IDLE;
            tmo_next   = '0;
            err_next   = 1'b1;
            busy_next  = 1'b0;
        end else begin
            tmo_next = tmo_reg + TW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            hi_reg    <= '0;
            tmo_reg   <= '0;
            fin_reg   <= 1'b0;
            we_reg    <= 1'b0;
            dout_reg  <= '0;
            a_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef BRAM16_LOADER_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            tmo_reg   <= tmo_next;
            fin_reg   <= fin_next;
            we_reg    <= we_next;
            dout_reg  <= dout_next;
            a_reg     <= a_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
`ifdef BRAM16_LOADER_CHECKSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    assign we   = we_reg;
    assign dout = dout_reg;
    assign a    = a_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: doc/bram16_loader.md
Name: bram16_loader

Overview:
- Boot-time loader that sits directly upstream of bram16 and drives its write port (we, do, a).
- Consumes a byte stream from the UART receiver (rx_data/rx_stb).
- Parses a framed load command: sync byte, 16-bit start address, 16-bit word count, then big-endian data words.
- Writes each word into bram16, one single-cycle write per word, while holding the core in reset through busy.

Parameters:
- SYNC, 8'hA5: frame start byte.
- TIMEOUT, 24'd1000000: maximum idle cycles between bytes inside a frame before abort.
- TW, 24: width of the timeout counter. Must satisfy TIMEOUT < 2^TW.

Ports:
- sys_clk  in  1: system clock; all logic on its rising edge.
- sys_rst  in  1: synchronous, active-high reset.
- rx_data  in  8: received byte; valid only when rx_stb=1.
- rx_stb  in  1: one-cycle strobe, byte available. May assert on consecutive cycles.
- we  out  1: bram16 write enable; single-cycle pulse per word.
- do  out  16: bram16 write data.
- a  out  16: bram16 word address.
- busy  out  1: high from sync accepted to end of frame; drives core reset.
- done  out  1: one-cycle pulse, frame loaded successfully.
- err  out  1: one-cycle pulse, frame aborted (timeout or checksum).

Behaviour:
- Reset values: we=0, do=0, a=0, busy=0, done=0, err=0, state=IDLE, timeout counter=0, checksum=0.
- All outputs are registered.
- sys_rst mid-frame returns to IDLE immediately. The frame is discarded and no done or err pulse is raised.
- States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, and CSUM (macro only).
- IDLE:
  - rx_stb with rx_data==SYNC -> ADDR_H, busy=1, checksum cleared.
  - Any other byte is ignored, with no err.
- ADDR_H/ADDR_L: latch the start address high byte then low byte.
- CNT_H/CNT_L: latch the 16-bit word count, high byte first.
  - On CNT_L with count==0: no writes. Go to CSUM if enabled, else pulse done, busy=0, go to IDLE.
- DATA_H: latch the high byte.
- DATA_L: on rx_stb, on the next edge drive we=1, do={hi,lo}, a=current address.
  - The address increments afterwards, modulo 2^16: 0xFFFF wraps to 0x0000.
  - Remaining count decrements.
  - If remaining count is non-zero -> DATA_H.
  - Else: last write cycle also finishes the frame (go to CSUM, or pulse done the cycle after we).
- Write latency: we asserts exactly 1 cycle after the rx_stb carrying the low byte.
  - we is high for exactly 1 cycle; a and do hold their values until the next write.
- A byte arriving on the same cycle as we=1 is accepted normally; there is no stall path.
- Timeout:
  - Counter clears on every rx_stb and counts while state is not IDLE.
  - Reaching TIMEOUT -> err pulse, busy=0, IDLE.
  - Words already written stay in bram16.
- done and err are mutually exclusive and never assert in IDLE without a preceding frame.
- busy falls on the same edge that raises done or err.

Optional Feature:
- Macro: BRAM16_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR checksum accumulates every byte after SYNC: address, count and data bytes.
  - After the last data byte (or CNT_L when count==0), enter CSUM.
  - The next byte is compared with the accumulated checksum. Equal -> done pulse; mismatch -> err pulse; both then return to IDLE with busy=0.
  - Writes already issued are not rolled back.
- Undefined: no CSUM state and no checksum logic; the frame ends after the last data word.

Test Plan:
- Reset: hold sys_rst 2 cycles -> we=0, a=0, do=0, busy=0, done=0, err=0.
- Basic load: bytes A5 01 00 00 02 12 34 56 78 ->
  - we pulses at a=0x0100 do=0x1234, then a=0x0101 do=0x5678.
  - Readback via bram16 returns 0x1234 and 0x5678.
  - done pulses once and busy falls.
  - With the macro, append checksum byte 0x01^0x00^0x00^0x02^0x12^0x34^0x56^0x78 = 0x0B.
- Wrap and back-to-back: A5 FF FF 00 02 then 4 data bytes on consecutive cycles -> writes land at 0xFFFF then 0x0000, each we exactly 1 cycle.
- Garbage and zero count: bytes 00 3C before A5 are ignored. Frame A5 10 00 00 00 -> no we, done pulse (macro: after checksum byte 0x10).
- Timeout: with TIMEOUT=16, send A5 02 00 00 03 11 22 and stop -> one write at 0x0200 = 0x1122, err pulse 16 cycles after last byte, busy=0.
- Reset mid-frame and bad checksum: sys_rst after the 3rd data byte -> IDLE, no done or err. Macro build, bad checksum byte -> err pulse, data words still written.
